// File: rtl/debug_pkg.sv
// Shared definitions for the debug/loader block: command bytes, dump size
// and the top-level state encoding.
package debug_pkg;

   localparam logic [7:0] CMD_LOAD = 8'h4C;
   localparam logic [7:0] CMD_RUN  = 8'h52;
   localparam logic [7:0] CMD_STEP = 8'h53;
   localparam logic [7:0] ACK_BYTE = 8'h4B;

   localparam int DUMP_BYTES = 136;
   localparam int NB_DUMP_IDX = $clog2(DUMP_BYTES);

   typedef enum logic [3:0] {
      ST_IDLE       = 4'd0,
      ST_LOAD_CNT   = 4'd1,
      ST_LOAD_BYTE  = 4'd2,
      ST_LOAD_WRITE = 4'd3,
      ST_ACK        = 4'd4,
      ST_RUN        = 4'd5,
      ST_STEP       = 4'd6,
      ST_DUMP_SEND  = 4'd7,
      ST_DUMP_WAIT  = 4'd8
   } state_t;

endpackage

// File: rtl/debug_tx_seq.sv
// Byte-indexed serializer for the debug dump (PC, cycle count, r0..r31) and
// the single ACK byte; owns the registered transmitter outputs.
module debug_tx_seq
   import debug_pkg::*;
#(
   parameter int NB_DATA           = 32,
   parameter int N_REGISTERS       = 32,
   parameter int NB_ADDR_REGISTERS = $clog2(N_REGISTERS)
)(
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  state_t                       i_state,
   input  logic                         i_tx_ready,
   input  logic [NB_DATA-1:0]           i_pc,
   input  logic [NB_DATA-1:0]           i_cycles,
   input  logic [NB_DATA-1:0]           i_reg_rd_data,
   output logic [NB_ADDR_REGISTERS-1:0] o_reg_rd_addr,
   output logic [7:0]                   o_tx_data,
   output logic                         o_tx_start,
   output logic                         o_last
);

   logic [NB_DUMP_IDX-1:0] r_idx;
   logic [NB_DATA-1:0]     w_word;
   logic [7:0]             w_byte;
   logic                   w_fire;

   // Bytes 0-7 come from the snapshot, the rest from the live register read.
   always_comb begin
      w_word = i_reg_rd_data;
      if (r_idx < NB_DUMP_IDX'(4))
         w_word = i_pc;
      else if (r_idx < NB_DUMP_IDX'(8))
         w_word = i_cycles;
      w_byte = w_word[{r_idx[1:0], 3'b000} +: 8];
   end

   assign o_reg_rd_addr = NB_ADDR_REGISTERS'((r_idx - NB_DUMP_IDX'(8)) >> 2);
   assign o_last        = (r_idx == NB_DUMP_IDX'(DUMP_BYTES - 1));
   assign w_fire        = ((i_state == ST_DUMP_SEND) || (i_state == ST_ACK)) && i_tx_ready;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_idx      <= '0;
         o_tx_data  <= 8'h00;
         o_tx_start <= 1'b0;
      end else begin
         o_tx_start <= w_fire;
         if (w_fire)
            o_tx_data <= (i_state == ST_ACK) ? ACK_BYTE : w_byte;
         if (i_state == ST_DUMP_WAIT)
            r_idx <= o_last ? '0 : r_idx + NB_DUMP_IDX'(1);
      end
   end

endmodule

// File: rtl/debug_unit.sv
// Command-driven loader/debugger ahead of the pipeline: loads instruction
// memory, runs or single-steps the pipeline, then dumps its state over UART.
module debug_unit
   import debug_pkg::*;
#(
   parameter int NB_DATA           = 32,
   parameter int NB_ADDRESS        = 32,
   parameter int N_ADDRESS         = 64,
   parameter int N_REGISTERS       = 32,
   parameter int NB_ADDR_REGISTERS = $clog2(N_REGISTERS)
)(
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic [7:0]                   i_rx_data,
   input  logic                         i_rx_valid,
   input  logic                         i_tx_ready,
   output logic [7:0]                   o_tx_data,
   output logic                         o_tx_start,
   output logic                         o_imem_w_en,
   output logic [NB_ADDRESS-1:0]        o_imem_w_addr,
   output logic [NB_DATA-1:0]           o_imem_w_data,
   output logic                         o_pipe_en,
   output logic                         o_pipe_reset,
   input  logic                         i_halt,
   input  logic [NB_DATA-1:0]           i_pc,
   output logic [NB_ADDR_REGISTERS-1:0] o_reg_rd_addr,
   input  logic [NB_DATA-1:0]           i_reg_rd_data
);

   state_t                r_state;
   logic [NB_ADDRESS-1:0] r_word_cnt;
   logic [NB_ADDRESS-1:0] r_word_addr;
   logic [1:0]            r_byte_idx;
   logic [NB_DATA-1:0]    r_word;
   logic [NB_DATA-1:0]    r_cycles;
   logic [NB_DATA-1:0]    r_snap_pc;
   logic [NB_DATA-1:0]    r_snap_cycles;
   logic                  r_pipe_reset;
   logic [NB_ADDRESS-1:0] w_cnt_in;
   logic                  w_last;

   assign w_cnt_in = (NB_ADDRESS'(i_rx_data) > NB_ADDRESS'(N_ADDRESS)) ?
                     NB_ADDRESS'(N_ADDRESS) : NB_ADDRESS'(i_rx_data);

   assign o_pipe_en     = ((r_state == ST_RUN) && !i_halt) || (r_state == ST_STEP);
   assign o_imem_w_en   = (r_state == ST_LOAD_WRITE);
   assign o_imem_w_addr = r_word_addr;
   assign o_imem_w_data = r_word;
   assign o_pipe_reset  = r_pipe_reset;

   // Words arrive LSB first, so each new byte is shifted in from the top.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= ST_IDLE;
         r_word_cnt    <= '0;
         r_word_addr   <= '0;
         r_byte_idx    <= '0;
         r_word        <= '0;
         r_cycles      <= '0;
         r_snap_pc     <= '0;
         r_snap_cycles <= '0;
         r_pipe_reset  <= 1'b0;
      end else begin
         r_pipe_reset <= 1'b0;
         if (o_pipe_en)
            r_cycles <= r_cycles + NB_DATA'(1);
         case (r_state)
            ST_IDLE: begin
               if (i_rx_valid) begin
                  if (i_rx_data == CMD_LOAD)
                     r_state <= ST_LOAD_CNT;
                  else if (i_rx_data == CMD_RUN)
                     r_state <= ST_RUN;
                  else if (i_rx_data == CMD_STEP)
                     r_state <= ST_STEP;
               end
            end
            ST_LOAD_CNT: begin
               if (i_rx_valid) begin
                  r_word_cnt  <= w_cnt_in;
                  r_word_addr <= '0;
                  r_byte_idx  <= '0;
                  r_state     <= (i_rx_data == 8'h00) ? ST_IDLE : ST_LOAD_BYTE;
               end
            end
            ST_LOAD_BYTE: begin
               if (i_rx_valid) begin
                  r_word     <= {i_rx_data, r_word[NB_DATA-1:8]};
                  r_byte_idx <= r_byte_idx + 2'd1;
                  if (r_byte_idx == 2'd3)
                     r_state <= ST_LOAD_WRITE;
               end
            end
            ST_LOAD_WRITE: begin
               if (r_word_addr == r_word_cnt - NB_ADDRESS'(1)) begin
                  r_pipe_reset <= 1'b1;
                  r_cycles     <= '0;
                  r_state      <= ST_ACK;
               end else begin
                  r_word_addr <= r_word_addr + NB_ADDRESS'(1);
                  r_state     <= ST_LOAD_BYTE;
               end
            end
            ST_ACK: begin
               if (i_tx_ready)
                  r_state <= ST_IDLE;
            end
            ST_RUN: begin
               if (i_halt) begin
                  r_snap_pc     <= i_pc;
                  r_snap_cycles <= r_cycles;
                  r_state       <= ST_DUMP_SEND;
               end
            end
            ST_STEP: begin
               r_snap_pc     <= i_pc;
               r_snap_cycles <= r_cycles + NB_DATA'(1);
               r_state       <= ST_DUMP_SEND;
            end
            ST_DUMP_SEND: begin
               if (i_tx_ready)
                  r_state <= ST_DUMP_WAIT;
            end
            ST_DUMP_WAIT: begin
               r_state <= w_last ? ST_IDLE : ST_DUMP_SEND;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   debug_tx_seq #(
      .NB_DATA          (NB_DATA),
      .N_REGISTERS      (N_REGISTERS),
      .NB_ADDR_REGISTERS(NB_ADDR_REGISTERS)
   ) u_tx_seq (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_state      (r_state),
      .i_tx_ready   (i_tx_ready),
      .i_pc         (r_snap_pc),
      .i_cycles     (r_snap_cycles),
      .i_reg_rd_data(i_reg_rd_data),
      .o_reg_rd_addr(o_reg_rd_addr),
      .o_tx_data    (o_tx_data),
      .o_tx_start   (o_tx_start),
      .o_last       (w_last)
   );

endmodule

// File: tb/tb_debug_unit.sv
// Scoreboard bench for debug_unit: expected tx bytes and imem writes are
// queued as stimulus is driven and popped as the DUT produces them.
module tb_debug_unit;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic [7:0]  i_rx_data = 8'h00;
   logic        i_rx_valid = 1'b0;
   logic        i_tx_ready = 1'b1;
   logic [7:0]  o_tx_data;
   logic        o_tx_start;
   logic        o_imem_w_en;
   logic [31:0] o_imem_w_addr;
   logic [31:0] o_imem_w_data;
   logic        o_pipe_en;
   logic        o_pipe_reset;
   logic        i_halt = 1'b0;
   logic [31:0] i_pc = 32'h0;
   logic [4:0]  o_reg_rd_addr;
   logic [31:0] i_reg_rd_data;

   logic [7:0]  regSeed = 8'h00;
   logic [7:0]  txQ[$];
   logic [31:0] wAddrQ[$];
   logic [31:0] wDataQ[$];
   int          compareCount = 0;
   int          mismatchCount = 0;
   int          txSent = 0;
   int          writeCount = 0;
   int          pipeEnTotal = 0;
   int          pipeResetCount = 0;
   logic        prevWen = 1'b0;

   always #5 i_clk = ~i_clk;

   function automatic logic [31:0] regValue(input logic [4:0] a, input logic [7:0] seed);
      return {seed, 3'b000, a, 8'hC3 ^ {3'b000, a}, 8'h5A};
   endfunction

   assign i_reg_rd_data = regValue(o_reg_rd_addr, regSeed);

   debug_unit dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_rx_data    (i_rx_data),
      .i_rx_valid   (i_rx_valid),
      .i_tx_ready   (i_tx_ready),
      .o_tx_data    (o_tx_data),
      .o_tx_start   (o_tx_start),
      .o_imem_w_en  (o_imem_w_en),
      .o_imem_w_addr(o_imem_w_addr),
      .o_imem_w_data(o_imem_w_data),
      .o_pipe_en    (o_pipe_en),
      .o_pipe_reset (o_pipe_reset),
      .i_halt       (i_halt),
      .i_pc         (i_pc),
      .o_reg_rd_addr(o_reg_rd_addr),
      .i_reg_rd_data(i_reg_rd_data)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Monitor: pops the scoreboards whenever the DUT sends a byte or writes memory.
   always @(negedge i_clk) begin
      if (!i_reset) begin
         if (o_tx_start) begin
            txSent++;
            if (txQ.size() == 0)
               checkOutput("txUnexpected", 32'(txQ.size()), 32'd1);
            else
               checkOutput("txByte", {24'd0, o_tx_data}, {24'd0, txQ.pop_front()});
         end
         if (o_imem_w_en) begin
            writeCount++;
            if (wAddrQ.size() == 0)
               checkOutput("wrUnexpected", 32'(wAddrQ.size()), 32'd1);
            else begin
               checkOutput("wrAddr", o_imem_w_addr, wAddrQ.pop_front());
               checkOutput("wrData", o_imem_w_data, wDataQ.pop_front());
            end
         end
         if (o_pipe_reset) begin
            pipeResetCount++;
            checkOutput("pipeResetAfterWrite", {31'd0, prevWen}, 32'd1);
         end
         if (o_pipe_en)
            pipeEnTotal++;
      end
      prevWen = o_imem_w_en;
   end

   task automatic applyStimulus(input logic [7:0] b);
      @(posedge i_clk);
      #1 i_rx_data = b;
      i_rx_valid = 1'b1;
      @(posedge i_clk);
      #1 i_rx_valid = 1'b0;
   endtask

   task automatic applyReset();
      @(posedge i_clk);
      #1 i_reset = 1'b1;
      repeat (2) @(posedge i_clk);
      #1 i_reset = 1'b0;
   endtask

   task automatic expectDump(input logic [31:0] pc, input logic [31:0] cyc, input logic [7:0] seed);
      logic [31:0] w;
      for (int b = 0; b < 4; b++) txQ.push_back(pc[8*b +: 8]);
      for (int b = 0; b < 4; b++) txQ.push_back(cyc[8*b +: 8]);
      for (int r = 0; r < 32; r++) begin
         w = regValue(5'(r), seed);
         for (int b = 0; b < 4; b++) txQ.push_back(w[8*b +: 8]);
      end
   endtask

   task automatic expectWord(input logic [31:0] addr, input logic [31:0] data);
      wAddrQ.push_back(addr);
      wDataQ.push_back(data);
   endtask

   task automatic waitDrain(input string tag, input int maxCycles);
      int n = 0;
      while ((txQ.size() != 0 || wAddrQ.size() != 0) && n < maxCycles) begin
         @(posedge i_clk);
         n++;
      end
      checkOutput({tag, "Drain"}, 32'(txQ.size() + wAddrQ.size()), 32'd0);
      repeat (4) @(posedge i_clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int enCount;
      int n;
      int base;
      int snap;
      logic [7:0] b;

      applyReset();
      @(negedge i_clk);
      checkOutput("rstTxData", {24'd0, o_tx_data}, 32'd0);
      checkOutput("rstTxStart", {31'd0, o_tx_start}, 32'd0);
      checkOutput("rstWen", {31'd0, o_imem_w_en}, 32'd0);
      checkOutput("rstWaddr", o_imem_w_addr, 32'd0);
      checkOutput("rstPipeEn", {31'd0, o_pipe_en}, 32'd0);
      checkOutput("rstPipeReset", {31'd0, o_pipe_reset}, 32'd0);

      // Two-word load followed by acknowledge.
      base = pipeResetCount;
      expectWord(32'd0, 32'h44332211);
      expectWord(32'd1, 32'h88776655);
      txQ.push_back(8'h4B);
      applyStimulus(8'h4C);
      applyStimulus(8'h02);
      for (int k = 1; k <= 8; k++) applyStimulus(8'((k << 4) | k));
      waitDrain("load2", 200);
      checkOutput("load2PipeReset", 32'(pipeResetCount - base), 32'd1);

      // Run for ten enabled cycles, then halt and dump.
      i_pc = 32'h0000_0028;
      regSeed = 8'h11;
      base = pipeEnTotal;
      expectDump(32'h0000_0028, 32'd10, 8'h11);
      applyStimulus(8'h52);
      enCount = 0;
      n = 0;
      while (enCount < 10 && n < 200) begin
         @(negedge i_clk);
         if (o_pipe_en) enCount++;
         n++;
      end
      checkOutput("runEnSeen", 32'(enCount), 32'd10);
      @(posedge i_clk);
      #1 i_halt = 1'b1;
      waitDrain("run", 1000);
      checkOutput("runEnCycles", 32'(pipeEnTotal - base), 32'd10);
      i_halt = 1'b0;

      // Zero-count load is a no-op; two steps follow, one with tx stalled.
      applyReset();
      base = writeCount;
      snap = txSent;
      applyStimulus(8'h4C);
      applyStimulus(8'h00);
      repeat (4) @(posedge i_clk);
      checkOutput("load0NoWrite", 32'(writeCount - base), 32'd0);
      checkOutput("load0NoAck", 32'(txSent - snap), 32'd0);
      i_pc = 32'h0000_0100;
      regSeed = 8'h22;
      base = pipeEnTotal;
      expectDump(32'h0000_0100, 32'd1, 8'h22);
      applyStimulus(8'h53);
      n = 0;
      while (txSent < snap + 40 && n < 500) begin
         @(posedge i_clk);
         n++;
      end
      #1 i_tx_ready = 1'b0;
      @(posedge i_clk);
      #1 base = base;
      snap = txSent;
      repeat (18) @(posedge i_clk);
      #1 checkOutput("holdNoSend", 32'(txSent), 32'(snap));
      i_tx_ready = 1'b1;
      waitDrain("step1", 1000);
      checkOutput("step1EnCycles", 32'(pipeEnTotal - base), 32'd1);
      i_pc = 32'h0000_0104;
      regSeed = 8'h33;
      base = pipeEnTotal;
      expectDump(32'h0000_0104, 32'd2, 8'h33);
      applyStimulus(8'h53);
      waitDrain("step2", 1000);
      checkOutput("step2EnCycles", 32'(pipeEnTotal - base), 32'd1);

      // Oversized count saturates to 64 words.
      applyReset();
      base = pipeResetCount;
      for (int k = 0; k < 64; k++)
         expectWord(32'(k), {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
      txQ.push_back(8'h4B);
      applyStimulus(8'h4C);
      applyStimulus(8'hFF);
      for (int k = 0; k < 256; k++) begin
         b = 8'(k);
         applyStimulus(b);
      end
      repeat (10) @(posedge i_clk);
      waitDrain("load64", 200);
      checkOutput("load64PipeReset", 32'(pipeResetCount - base), 32'd1);

      // Reset in the middle of a load aborts with no write; IDLE accepts a step.
      applyReset();
      base = writeCount;
      applyStimulus(8'h4C);
      applyStimulus(8'h02);
      applyStimulus(8'hAA);
      applyStimulus(8'hBB);
      applyReset();
      repeat (4) @(posedge i_clk);
      checkOutput("abortNoWrite", 32'(writeCount - base), 32'd0);
      i_pc = 32'h0000_0200;
      regSeed = 8'h44;
      expectDump(32'h0000_0200, 32'd1, 8'h44);
      applyStimulus(8'h53);
      waitDrain("abortStep", 1000);
      checkOutput("abortNoWriteEnd", 32'(writeCount - base), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule

// File: doc/debug_unit.md
# debug_unit

Command-driven debug/loader block sitting directly upstream of the five-stage `pipeline`. It consumes bytes from a UART receiver and loads program words into the instruction memory. It gates the pipeline clock enable for continuous run or single-step. After every run or step it streams the PC, an executed-cycle count and all 32 registers back out through a UART transmitter.

## Interface
Parameters:
- `NB_DATA`, 32: data/word width.
- `NB_ADDRESS`, 32: instruction-memory address width (word address).
- `N_ADDRESS`, 64: instruction-memory depth in words.
- `N_REGISTERS`, 32: register count; `NB_ADDR_REGISTERS` = clog2(`N_REGISTERS`).

Ports:
- `i_clk` in 1: single clock, shared with the pipeline.
- `i_reset` in 1: synchronous, active-high.
- `i_rx_data` in 8: received byte.
- `i_rx_valid` in 1: one-cycle pulse, `i_rx_data` valid.
- `i_tx_ready` in 1: transmitter idle.
- `o_tx_data` out 8: byte to send (registered).
- `o_tx_start` out 1: one-cycle send pulse.
- `o_imem_w_en` out 1: instruction-memory write strobe.
- `o_imem_w_addr` out `NB_ADDRESS`: word address.
- `o_imem_w_data` out `NB_DATA`: assembled word.
- `o_pipe_en` out 1: pipeline stage enable.
- `o_pipe_reset` out 1: one-cycle pipeline reset pulse.
- `i_halt` in 1: HALT instruction has reached WB.
- `i_pc` in `NB_DATA`: current IF PC.
- `o_reg_rd_addr` out `NB_ADDR_REGISTERS`: register-file debug read address.
- `i_reg_rd_data` in `NB_DATA`: combinational debug read data.

## Operation
- Commands are single bytes, accepted only in IDLE. All other bytes received in IDLE are dropped.
  - `'L'` (0x4C): load.
  - `'R'` (0x52): run.
  - `'S'` (0x53): step.
- Bytes arriving in RUN, STEP, DUMP or ACK are ignored.
- Load sequence:
  - LOAD_CNT: the next byte is word count N. N=0 returns to IDLE with no write. N>`N_ADDRESS` saturates to `N_ADDRESS`.
  - LOAD_BYTE: receive 4·N bytes, little-endian. Word k is written to address k, k=0..N-1.
  - After the last write: pulse `o_pipe_reset` for one cycle, clear the cycle counter, enter ACK.
  - ACK sends 0x4B (`'K'`), then returns to IDLE.
- RUN:
  - `o_pipe_en` = (state==RUN) && !`i_halt`, combinational.
  - The cycle counter (32 bit, wraps) increments on every cycle with `o_pipe_en`=1.
  - When `i_halt`=1, go to DUMP.
- STEP:
  - `o_pipe_en`=1 for exactly one cycle, even if `i_halt` is high.
  - Counter +1, then DUMP.
- DUMP streams 136 bytes, LSB first within each word:
  - PC: bytes 0–3.
  - Cycle counter: bytes 4–7.
  - r0..r31: bytes 8–135, with `o_reg_rd_addr` = (idx−8)>>2.
  - Then return to IDLE.
- TX handshake, states SEND/WAIT:
  - In SEND, when `i_tx_ready`=1, latch the byte into `o_tx_data` and pulse `o_tx_start` for one cycle.
  - WAIT lasts one cycle, then the index advances.
  - If `i_tx_ready`=0, hold in SEND.
- State set: IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WRITE, ACK, RUN, STEP, DUMP_SEND, DUMP_WAIT.

## Timing
- Reset values:
  - All outputs 0, `o_tx_data`=0x00, `o_imem_w_addr`=0.
  - State IDLE; cycle counter, byte index and word index all 0.
  - Reset mid-operation aborts immediately; no partial write is issued.
- Load writes:
  - The 4th byte is sampled in cycle t; `o_imem_w_en`=1 in cycle t+1 (LOAD_WRITE), with address and data stable for that cycle.
  - The next byte is accepted from t+2 onward.
- The pipeline reset pulse occurs in the cycle after the final write.
- RUN:
  - `o_pipe_en` drops in the same cycle `i_halt` rises; the halt cycle is neither clocked nor counted.
  - DUMP starts in the next cycle.
- The PC and counter are captured into a snapshot register on DUMP entry. Register bytes are read live; they are stable because `o_pipe_en`=0.
- Minimum of 2 cycles per dumped byte.

## Structure
- Shared package `debug_pkg`:
  - Command codes `CMD_LOAD`/`CMD_RUN`/`CMD_STEP`.
  - `ACK_BYTE`.
  - `DUMP_BYTES`=136.
  - State encoding constants.
- One natural sub-module: `debug_tx_seq`, the byte-indexed serializer handling DUMP_SEND/DUMP_WAIT and the `i_tx_ready` handshake.
- Top-level FSM and load assembly stay in `debug_unit`.

## Test plan
- Load: send 0x4C, 0x02, then 11 22 33 44 55 66 77 88. Required:
  - Writes (addr 0, 0x44332211) and (addr 1, 0x88776655).
  - One `o_pipe_reset` pulse.
  - Tx 0x4B.
- Load with count 0x00: no write, no ack, next byte 0x53 is accepted as a step.
- Count 0xFF: exactly 64 writes (addresses 0..63), then ack.
- Run with `i_halt` raised after 10 enabled cycles: `o_pipe_en` high 10 cycles, 136 bytes sent, bytes 4–7 = 0A 00 00 00.
- Step twice from reset: two dumps with counter 1 then 2. Each register word's bytes match `i_reg_rd_data` for the addressed register.
- `i_tx_ready` held low 20 cycles mid-dump: no byte lost or duplicated. Also: `i_reset` during LOAD_BYTE after 2 bytes gives no write and state IDLE.
